// File: rtl/vga_scanout_ctrl_pkg.sv
// Shared constants for the VGA scan-out path: buffer geometry, 640x480@60
// timing, signal widths and the colour-bar test pattern.
package vga_scanout_ctrl_pkg;

    localparam int IMAGE_ROW = 240;
    localparam int IMAGE_COL = 320;

    localparam int H_VISIBLE = 640;
    localparam int H_FRONT   = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BACK    = 48;

    localparam int V_VISIBLE = 480;
    localparam int V_FRONT   = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BACK    = 33;

    localparam int PIXEL_W = 12;
    localparam int ROW_W   = 8;
    localparam int COL_W   = 9;
    localparam int CNT_W   = 10;

    localparam int BAR_WIDTH = 80;

    localparam logic [PIXEL_W-1:0] BAR_C0 = 12'hFFF;
    localparam logic [PIXEL_W-1:0] BAR_C1 = 12'hFF0;
    localparam logic [PIXEL_W-1:0] BAR_C2 = 12'h0FF;
    localparam logic [PIXEL_W-1:0] BAR_C3 = 12'h0F0;
    localparam logic [PIXEL_W-1:0] BAR_C4 = 12'hF0F;
    localparam logic [PIXEL_W-1:0] BAR_C5 = 12'hF00;
    localparam logic [PIXEL_W-1:0] BAR_C6 = 12'h00F;
    localparam logic [PIXEL_W-1:0] BAR_C7 = 12'h000;

    // Colour of the vertical bar containing horizontal position h.
    function automatic logic [PIXEL_W-1:0] bar_color(input logic [CNT_W-1:0] h);
        logic [CNT_W-1:0] idx;
        idx = h / CNT_W'(BAR_WIDTH);
        case (idx)
            CNT_W'(0): return BAR_C0;
            CNT_W'(1): return BAR_C1;
            CNT_W'(2): return BAR_C2;
            CNT_W'(3): return BAR_C3;
            CNT_W'(4): return BAR_C4;
            CNT_W'(5): return BAR_C5;
            CNT_W'(6): return BAR_C6;
            default:   return BAR_C7;
        endcase
    endfunction

endpackage

// File: rtl/vga_scanout_ctrl_timing.sv
// vga_timing_gen: pixel-enable divider, horizontal/vertical position
// counters and the combinational sync/visible decode of the current position.
module vga_timing_gen
    import vga_scanout_ctrl_pkg::*;
#(
    parameter int CLK_DIV   = 4,
    parameter int H_VISIBLE = vga_scanout_ctrl_pkg::H_VISIBLE,
    parameter int H_FRONT   = vga_scanout_ctrl_pkg::H_FRONT,
    parameter int H_SYNC    = vga_scanout_ctrl_pkg::H_SYNC,
    parameter int H_BACK    = vga_scanout_ctrl_pkg::H_BACK,
    parameter int V_VISIBLE = vga_scanout_ctrl_pkg::V_VISIBLE,
    parameter int V_FRONT   = vga_scanout_ctrl_pkg::V_FRONT,
    parameter int V_SYNC    = vga_scanout_ctrl_pkg::V_SYNC,
    parameter int V_BACK    = vga_scanout_ctrl_pkg::V_BACK
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             o_pix_tick,
    output logic [CNT_W-1:0] o_h_cnt,
    output logic [CNT_W-1:0] o_v_cnt,
    output logic             o_hs0,
    output logic             o_vs0,
    output logic             o_vis0
);

    localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [CNT_W-1:0] V_LAST  = CNT_W'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
    localparam logic [CNT_W-1:0] H_VIS   = CNT_W'(H_VISIBLE);
    localparam logic [CNT_W-1:0] V_VIS   = CNT_W'(V_VISIBLE);
    localparam logic [CNT_W-1:0] HS_BEG  = CNT_W'(H_VISIBLE + H_FRONT);
    localparam logic [CNT_W-1:0] HS_END  = CNT_W'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [CNT_W-1:0] VS_BEG  = CNT_W'(V_VISIBLE + V_FRONT);
    localparam logic [CNT_W-1:0] VS_END  = CNT_W'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [DIV_W-1:0] r_div_cnt;
    logic [CNT_W-1:0] r_h_cnt;
    logic [CNT_W-1:0] r_v_cnt;
    logic             w_pix_tick;

    assign w_pix_tick = (r_div_cnt == DIV_LAST);

    // Divide the system clock down to one pixel tick every CLK_DIV clocks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          r_div_cnt <= '0;
        else if (w_pix_tick) r_div_cnt <= '0;
        else                 r_div_cnt <= r_div_cnt + 1'b1;
    end

    // Raster position; the line counter steps when the pixel counter wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (w_pix_tick) begin
            if (r_h_cnt == H_LAST) begin
                r_h_cnt <= '0;
                r_v_cnt <= (r_v_cnt == V_LAST) ? '0 : r_v_cnt + 1'b1;
            end else begin
                r_h_cnt <= r_h_cnt + 1'b1;
            end
        end
    end

    assign o_pix_tick = w_pix_tick;
    assign o_h_cnt    = r_h_cnt;
    assign o_v_cnt    = r_v_cnt;
    assign o_vis0     = (r_h_cnt < H_VIS) && (r_v_cnt < V_VIS);
    assign o_hs0      = (r_h_cnt >= HS_BEG) && (r_h_cnt < HS_END);
    assign o_vs0      = (r_v_cnt >= VS_BEG) && (r_v_cnt < VS_END);

endmodule

// File: rtl/vga_scanout_ctrl.sv
// VGA scan-out controller: reads the 320x240 frame buffer with 2x2 pixel
// doubling and drives registered 640x480 RGB444 plus syncs.
// Optional feature macro: VGA_TEST_PATTERN_EN adds the test_mode input, which
// replaces buffer data with eight vertical colour bars.
module vga_scanout_ctrl
    import vga_scanout_ctrl_pkg::*;
#(
    parameter int CLK_DIV     = 4,
    parameter bit SYNC_ACTIVE = 1'b0,
    parameter int H_VISIBLE   = vga_scanout_ctrl_pkg::H_VISIBLE,
    parameter int H_FRONT     = vga_scanout_ctrl_pkg::H_FRONT,
    parameter int H_SYNC      = vga_scanout_ctrl_pkg::H_SYNC,
    parameter int H_BACK      = vga_scanout_ctrl_pkg::H_BACK,
    parameter int V_VISIBLE   = vga_scanout_ctrl_pkg::V_VISIBLE,
    parameter int V_FRONT     = vga_scanout_ctrl_pkg::V_FRONT,
    parameter int V_SYNC      = vga_scanout_ctrl_pkg::V_SYNC,
    parameter int V_BACK      = vga_scanout_ctrl_pkg::V_BACK
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [PIXEL_W-1:0] pixel_in,
    output logic [ROW_W-1:0]   row_read,
    output logic [COL_W-1:0]   col_read,
    output logic [3:0]         vga_r,
    output logic [3:0]         vga_g,
    output logic [3:0]         vga_b,
    output logic               vga_hsync,
    output logic               vga_vsync,
    output logic               frame_start
`ifdef VGA_TEST_PATTERN_EN
    ,
    input  logic               test_mode
`endif
);

    logic               w_pix_tick;
    logic [CNT_W-1:0]   w_h_cnt;
    logic [CNT_W-1:0]   w_v_cnt;
    logic               w_hs0;
    logic               w_vs0;
    logic               w_vis0;
    logic [PIXEL_W-1:0] w_pix_sel;

    logic [ROW_W-1:0]   r_row;
    logic [COL_W-1:0]   r_col;
    logic               r_vis1;
    logic               r_hs1;
    logic               r_vs1;
    logic               r_first1;
    logic [PIXEL_W-1:0] r_rgb;
    logic               r_hsync;
    logic               r_vsync;
    logic               r_frame_start;

    vga_timing_gen #(
        .CLK_DIV   (CLK_DIV),
        .H_VISIBLE (H_VISIBLE),
        .H_FRONT   (H_FRONT),
        .H_SYNC    (H_SYNC),
        .H_BACK    (H_BACK),
        .V_VISIBLE (V_VISIBLE),
        .V_FRONT   (V_FRONT),
        .V_SYNC    (V_SYNC),
        .V_BACK    (V_BACK)
    ) u_timing (
        .clk        (clk),
        .rst_n      (rst_n),
        .o_pix_tick (w_pix_tick),
        .o_h_cnt    (w_h_cnt),
        .o_v_cnt    (w_v_cnt),
        .o_hs0      (w_hs0),
        .o_vs0      (w_vs0),
        .o_vis0     (w_vis0)
    );

    // Address stage: halve the raster position into a buffer address, park
    // the address at 0 in blanking, and carry sync/visible along with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_row    <= '0;
            r_col    <= '0;
            r_vis1   <= 1'b0;
            r_hs1    <= 1'b0;
            r_vs1    <= 1'b0;
            r_first1 <= 1'b0;
        end else if (w_pix_tick) begin
            r_col    <= w_vis0 ? w_h_cnt[COL_W:1] : '0;
            r_row    <= w_vis0 ? w_v_cnt[ROW_W:1] : '0;
            r_vis1   <= w_vis0;
            r_hs1    <= w_hs0;
            r_vs1    <= w_vs0;
            r_first1 <= (w_h_cnt == '0) && (w_v_cnt == '0);
        end
    end

`ifdef VGA_TEST_PATTERN_EN
    logic [PIXEL_W-1:0] r_bar1;

    // Bar colour is chosen from the same raster position as the address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          r_bar1 <= '0;
        else if (w_pix_tick) r_bar1 <= bar_color(w_h_cnt);
    end

    assign w_pix_sel = test_mode ? r_bar1 : pixel_in;
`else
    assign w_pix_sel = pixel_in;
`endif

    // Data stage: the buffer has answered by now; register colour and syncs
    // together so they leave the block aligned.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rgb         <= '0;
            r_hsync       <= ~SYNC_ACTIVE;
            r_vsync       <= ~SYNC_ACTIVE;
            r_frame_start <= 1'b0;
        end else begin
            r_frame_start <= w_pix_tick && r_first1;
            if (w_pix_tick) begin
                r_rgb   <= r_vis1 ? w_pix_sel : '0;
                r_hsync <= r_hs1 ? SYNC_ACTIVE : ~SYNC_ACTIVE;
                r_vsync <= r_vs1 ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            end
        end
    end

    assign row_read    = r_row;
    assign col_read    = r_col;
    assign vga_r       = r_rgb[11:8];
    assign vga_g       = r_rgb[7:4];
    assign vga_b       = r_rgb[3:0];
    assign vga_hsync   = r_hsync;
    assign vga_vsync   = r_vsync;
    assign frame_start = r_frame_start;

endmodule
